// File: rtl/lap_reader.sv
// Host-side controller for the stopwatch block: turns start/stop/lap commands into
// capture/read strobe sequences and queues each sample with its lap delta in a FWFT FIFO.
module lap_reader #(
    parameter int DEPTH    = 4,
    parameter int GAP      = 1,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     lap,
    input  logic                     pop,
    output logic                     watch_enable,
    output logic                     watch_capture,
    output logic                     watch_read,
    input  logic [7:0]               watch_duration,
    output logic                     lap_valid,
    output logic [7:0]               lap_duration,
    output logic [7:0]               lap_delta,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        CAP    = 3'd2,
        GAPW   = 3'd3,
        RD     = 3'd4,
        WAITL  = 3'd5,
        SAMPLE = 3'd6
    } state_t;

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (GAP > READ_LAT) ? GAP : READ_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            stop_pend;
    logic [7:0]      prev;

    logic [7:0]      mem_dur [DEPTH];
    logic [7:0]      mem_dlt [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, full, do_pop, do_write;
    logic [7:0]      sample_delta;

    // State register plus the per-state dwell counter, which restarts on every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = RUN;
            RUN: begin
                if (stop)     state_next = IDLE;
                else if (lap) state_next = CAP;
            end
            CAP:    state_next = GAPW;
            GAPW:   if (cnt == CW'(GAP - 1)) state_next = RD;
            RD:     state_next = (READ_LAT == 1) ? SAMPLE : WAITL;
            WAITL:  if (cnt == CW'(READ_LAT - 2)) state_next = SAMPLE;
            SAMPLE: state_next = (stop_pend || stop) ? IDLE : RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        watch_enable  = (state != IDLE);
        watch_capture = (state == CAP);
        watch_read    = (state == RD);
        busy          = (state == CAP) || (state == GAPW) || (state == RD) ||
                        (state == WAITL) || (state == SAMPLE);
        fsm_state     = state;
    end

    // A stop seen mid-sequence is held until the sample has been pushed.
    always_ff @(posedge clk) begin
        if (reset)
            stop_pend <= 1'b0;
        else if (state == IDLE || state == RUN || state == SAMPLE)
            stop_pend <= 1'b0;
        else if (stop)
            stop_pend <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            prev <= '0;
        else if (state == IDLE && start)
            prev <= '0;
        else if (state == SAMPLE)
            prev <= watch_duration;
    end

    assign push         = (state == SAMPLE);
    assign sample_delta = watch_duration - prev;
    assign full         = (fifo_count == (AW + 1)'(DEPTH));
    // Pop while empty only takes effect alongside a push: the new entry is consumed at once.
    assign do_pop       = pop && ((fifo_count != '0) || push);
    assign do_write     = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_dur[wr_ptr] <= watch_duration;
            mem_dlt[wr_ptr] <= sample_delta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !do_write) overflow <= 1'b1;
        end
    end

    assign lap_valid    = (fifo_count != '0);
    assign lap_duration = lap_valid ? mem_dur[rd_ptr] : 8'd0;
    assign lap_delta    = lap_valid ? mem_dlt[rd_ptr] : 8'd0;

endmodule

// File: tb/tb_lap_reader.sv
// Bench for lap_reader: a stopwatch model answers read pulses, and a scoreboard queue
// of {duration, delta} entries is checked as the host pops the FIFO.
module tb_lap_reader;

    localparam int DEPTH    = 4;
    localparam int GAP      = 1;
    localparam int READ_LAT = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, lap = 1'b0, pop = 1'b0;
    logic       watch_enable, watch_capture, watch_read;
    logic [7:0] watch_duration = 8'h5A;
    logic       lap_valid;
    logic [7:0] lap_duration, lap_delta;
    logic [2:0] fifo_count;
    logic       busy, overflow;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  model_prev = 8'd0;
    int          model_count = 0;
    logic        model_ovf = 1'b0;
    logic [7:0]  model_value = 8'd0;
    logic        rd_seen = 1'b0;

    lap_reader #(.DEPTH(DEPTH), .GAP(GAP), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lap(lap), .pop(pop),
        .watch_enable(watch_enable), .watch_capture(watch_capture), .watch_read(watch_read),
        .watch_duration(watch_duration), .lap_valid(lap_valid), .lap_duration(lap_duration),
        .lap_delta(lap_delta), .fifo_count(fifo_count), .busy(busy), .overflow(overflow),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Stopwatch model: duration is valid only in the cycle after a read pulse.
    always @(negedge clk) begin
        watch_duration = rd_seen ? model_value : 8'h5A;
        rd_seen = watch_read;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_prev = 8'd0;
        checks++;
        if (watch_enable !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_enable: got en=%b busy=%b expected en=1 busy=0", watch_enable, busy);
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (watch_enable !== 1'b0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL stop_enable: got en=%b state=%0d expected en=0 state=0", watch_enable, fsm_state);
        end
    endtask

    // One lap sequence; cycle c counts from the lap sampling edge.
    task automatic lap_seq(input logic [7:0] val, input bit pop_sample, input int stop_cycle);
        logic [7:0]  d;
        logic [15:0] head;
        logic [6:0]  got, exp;
        int cnt0, cnt1;
        cnt0 = model_count;
        cnt1 = cnt0;
        d = val - model_prev;
        model_prev = val;
        head = '0;
        if (pop_sample && cnt0 > 0) begin
            head = exp_q.pop_front();
            cnt1--;
        end
        if (pop_sample && cnt0 == 0) begin
            cnt1 = 0;
        end else if (cnt1 < DEPTH) begin
            exp_q.push_back({val, d});
            cnt1++;
        end else begin
            model_ovf = 1'b1;
        end
        model_value = val;
        lap = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            lap  = 1'b0;
            stop = (c == stop_cycle);
            exp = {c == 1, c == 2 + GAP, c <= 4, (c <= 4) || (stop_cycle == 0),
                   3'((c <= 4) ? cnt0 : cnt1)};
            got = {watch_capture, watch_read, busy, watch_enable, fifo_count};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lap_seq_c%0d: got cap/rd/busy/en/cnt=%b expected %b", c, got, exp);
            end
            if (c == 4 && pop_sample) begin
                if (cnt0 > 0) begin
                    checks++;
                    if ({lap_valid, lap_duration, lap_delta} !== {1'b1, head}) begin
                        errors++;
                        $display("FAIL pop_at_sample: got %b_%h_%h expected 1_%h", lap_valid, lap_duration, lap_delta, head);
                    end
                end
                pop = 1'b1;
            end else begin
                pop = 1'b0;
            end
        end
        stop = 1'b0;
        pop  = 1'b0;
        model_count = cnt1;
        @(negedge clk);
    endtask

    task automatic pop_check();
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_head: got valid=%b expected a queued entry", lap_valid);
        end else begin
            e = exp_q.pop_front();
            if ({lap_valid, lap_duration, lap_delta} !== {1'b1, e}) begin
                errors++;
                $display("FAIL pop_head: got %b dur=%0d dlt=%0d expected 1 dur=%0d dlt=%0d",
                         lap_valid, lap_duration, lap_delta, e[15:8], e[7:0]);
            end
            model_count--;
        end
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checks++;
        if (fifo_count !== 3'(model_count)) begin
            errors++;
            $display("FAIL pop_count: got %0d expected %0d", fifo_count, model_count);
        end
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            lap   = 1'($urandom_range(0, 1));
            pop   = 1'($urandom_range(0, 1));
            @(negedge clk);
            outs = {watch_enable, watch_capture, watch_read, lap_valid, lap_duration,
                    lap_delta, fifo_count, busy, overflow, fsm_state};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", outs);
            end
        end
        start = 1'b0; stop = 1'b0; lap = 1'b0; pop = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (fsm_state !== 3'd0 || watch_enable !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: got state=%0d en=%b cnt=%0d expected 0 0 0", fsm_state, watch_enable, fifo_count);
        end
    endtask

    task automatic test_basic();
        do_start();
        lap_seq(8'd25, 1'b0, 0);
        lap_seq(8'd60, 1'b0, 0);
        checks++;
        if (lap_duration !== 8'd25 || lap_delta !== 8'd25) begin
            errors++;
            $display("FAIL basic_head: got %0d/%0d expected 25/25", lap_duration, lap_delta);
        end
        pop_check();
        checks++;
        if (lap_duration !== 8'd60 || lap_delta !== 8'd35) begin
            errors++;
            $display("FAIL basic_second: got %0d/%0d expected 60/35", lap_duration, lap_delta);
        end
        pop_check();
    endtask

    task automatic test_wrap();
        do_stop();
        do_start();
        lap_seq(8'd250, 1'b0, 0);
        lap_seq(8'd4, 1'b0, 0);
        pop_check();
        checks++;
        if (lap_delta !== 8'd10) begin
            errors++;
            $display("FAIL wrap_delta: got %0d expected 10", lap_delta);
        end
        pop_check();
        do_stop();
        do_start();
        lap_seq(8'd7, 1'b0, 0);
        checks++;
        if (lap_delta !== 8'd7) begin
            errors++;
            $display("FAIL restart_delta: got %0d expected 7", lap_delta);
        end
        pop_check();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) lap_seq(8'(i * 10), 1'b0, 0);
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || model_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: got cnt=%0d ovf=%b expected cnt=4 ovf=1", fifo_count, overflow);
        end
        lap_seq(8'd60, 1'b1, 0);
        for (int i = 0; i < 4; i++) pop_check();
        lap_seq(8'd70, 1'b1, 0);
        lap_seq(8'd75, 1'b0, 0);
        checks++;
        if (lap_delta !== 8'd5) begin
            errors++;
            $display("FAIL empty_push_pop_delta: got %0d expected 5", lap_delta);
        end
        pop_check();
    endtask

    task automatic test_stop_gap();
        logic [3:0] got;
        lap_seq(8'd33, 1'b0, 2);
        lap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {watch_capture, watch_read, busy, watch_enable};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL idle_lap: got cap/rd/busy/en=%b expected 0000", got);
            end
        end
        lap = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [8:0] got;
        do_start();
        model_value = 8'd99;
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (watch_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_read: got %b expected 1", watch_read);
        end
        reset = 1'b1;
        @(negedge clk);
        got = {watch_read, watch_enable, watch_capture, lap_valid, fifo_count, overflow, busy};
        checks++;
        if (got !== '0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b state=%0d expected 0 state=0", got, fsm_state);
        end
        reset = 1'b0;
        exp_q.delete();
        model_count = 0;
        model_prev = 8'd0;
        model_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || lap_valid !== 1'b0 || watch_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got cnt=%0d valid=%b en=%b expected 0 0 0", fifo_count, lap_valid, watch_enable);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_stop_gap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
